mem_arbiter_resp: RTL
=====================

Name: mem_arbiter_resp

Overview:
- Memory-side responder for the cache request/wait protocol. It accepts single-word read and write requests from the dcache controller (dREN/dWEN) and read requests from the icache (iREN).
- It arbitrates between the two, drives one shared RAM port, and models a fixed access latency.
- It deasserts the granted cache's wait for exactly one cycle when the word completes.
- It sits between the two cache control units and the RAM.

Parameters:
- LAT, 2, RAM access latency in cycles per word; legal range 1..15.
- AW, 32, address and data width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- dREN  in  1  dcache read request, level, held until dwait low
- dWEN  in  1  dcache write request, level, held until dwait low
- daddr  in  AW  dcache word address
- dstore  in  AW  dcache write data
- iREN  in  1  icache read request, level
- iaddr  in  AW  icache word address
- dwait  out  1  low for one cycle = dcache word complete
- iwait  out  1  low for one cycle = icache word complete
- dload  out  AW  read data to dcache, valid when dwait low
- iload  out  AW  read data to icache, valid when iwait low
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  AW  RAM address
- ramstore  out  AW  RAM write data
- ramload  in  AW  RAM read data, valid on last latency cycle

Behaviour:
- Reset is asynchronous, active-low; clock is CLK. On reset:
  - state=IDLE, cnt=0, last_d=0.
  - Outputs: dwait=1, iwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- dload and iload are wired to ramload continuously.
- States: IDLE, DBUSY, IBUSY.
- IDLE:
  - No RAM strobes; both waits high.
  - Grant rule:
    - dreq=dREN|dWEN.
    - If dreq & iREN & last_d -> IBUSY.
    - Else if dreq -> DBUSY.
    - Else if iREN -> IBUSY.
    - Else stay.
  - On any grant, cnt<=LAT-1.
- DBUSY:
  - ramaddr=daddr; ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both are asserted).
  - Inputs are passed through live, not latched.
  - If cnt!=0: cnt<=cnt-1, dwait=1.
  - If cnt==0: dwait=0 this cycle (completion), last_d<=1, next IDLE.
- IBUSY:
  - ramaddr=iaddr; ramREN=1; ramWEN=0.
  - If cnt==0: iwait=0, last_d<=0, next IDLE; else decrement.
- Latency: from the cycle a request is first high in IDLE, completion occurs LAT cycles later, so wait is low in cycle LAT+1 counting the request cycle as 1.
- Back-to-back: one IDLE bubble cycle between consecutive words from the same master.
- Abort: if the granted master drops its request while BUSY (dreq=0 in DBUSY, iREN=0 in IBUSY):
  - Go to IDLE next cycle, no completion pulse, last_d unchanged.
  - RAM strobes drop in the same cycle, since they are combinational from the inputs.
- Mode change mid-access (dREN->dWEN while DBUSY): the counter is not restarted; the completion applies to the current mode.
- The ungranted wait is always 1; at most one wait is low in any cycle.
- Fairness: under continuous contention grants alternate D,I,D,I. Without contention the dcache has strict priority.
- LAT=1: completion occurs in the first BUSY cycle.
- cnt width is 4 bits, with no wrap: cnt only decrements while nonzero.
- Reset mid-access: immediate return to IDLE; the in-flight word is not completed.

Test Plan:
- LAT=2, dREN=1 daddr=0x40 from cycle 1, ramload=0xDEADBEEF -> DBUSY cycles 2-3, ramREN=1 ramaddr=0x40; dwait=0 in cycle 3 only, dload=0xDEADBEEF; IDLE in cycle 4.
- dWEN=1 daddr=0x80 dstore=0x12345678, dREN also 1 -> ramWEN=1, ramREN=0, ramstore=0x12345678 for 2 cycles; one dwait low pulse.
- dREN and iREN both held high for 4 completions -> grant order D,I,D,I; dwait and iwait never low in the same cycle; each pulse separated by an IDLE cycle.
- iREN=1 iaddr=0x100 alone, LAT=1 -> iwait=0 on the cycle after the request, ramaddr=0x100 in that cycle; dwait stays 1.
- dREN granted, dropped after 1 BUSY cycle with LAT=3 -> no dwait pulse; IDLE next; a following iREN is granted normally (last_d unchanged).
- nRST asserted during IBUSY with cnt=1 -> outputs immediately revert to reset values (ramREN=0, both waits=1); after release a pending iREN restarts with the full LAT count.

Source files
------------

// File: rtl/mem_arbiter_resp.sv
// rtl/mem_arbiter_resp.sv - memory-side responder arbitrating dcache and icache onto one RAM port
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   dREN, dWEN           dcache read/write request (level, held until dwait low)
//   daddr, dstore        dcache word address / write data
//   iREN, iaddr          icache read request / word address
//   dwait, iwait         low for exactly one cycle when the granted word completes
//   dload, iload         read data back to the caches (straight from ramload)
//   ramREN, ramWEN       RAM read/write strobes
//   ramaddr, ramstore    RAM address / write data
//   ramload              RAM read data, valid on the last latency cycle
module mem_arbiter_resp #(
    parameter int LAT = 2,
    parameter int AW  = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [AW-1:0] dstore,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          dwait,
    output logic          iwait,
    output logic [AW-1:0] dload,
    output logic [AW-1:0] iload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [AW-1:0] ramstore,
    input  logic [AW-1:0] ramload
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DBUSY = 2'd1,
        IBUSY = 2'd2
    } state_t;

    // Counter is loaded on grant and counts down to the completion cycle.
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       last_d, next_last_d;
    logic       dreq;

    assign dreq  = dREN | dWEN;
    assign dload = ramload;
    assign iload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            last_d <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            last_d <= next_last_d;
        end
    end

    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_last_d = last_d;
        dwait       = 1'b1;
        iwait       = 1'b1;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state)
            IDLE: begin
                // last_d breaks ties so contention alternates D,I,D,I;
                // without contention the dcache wins outright.
                if (dreq && iREN && last_d) begin
                    next_state = IBUSY;
                    next_cnt   = CNT_LOAD;
                end else if (dreq) begin
                    next_state = DBUSY;
                    next_cnt   = CNT_LOAD;
                end else if (iREN) begin
                    next_state = IBUSY;
                    next_cnt   = CNT_LOAD;
                end
            end

            DBUSY: begin
                // Request lines pass through live; a write overrides a
                // simultaneous read, and a mode change keeps the count.
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!dreq) begin
                    next_state = IDLE;
                end else if (cnt == 4'd0) begin
                    dwait       = 1'b0;
                    next_last_d = 1'b1;
                    next_state  = IDLE;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end

            IBUSY: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (cnt == 4'd0) begin
                    iwait       = 1'b0;
                    next_last_d = 1'b0;
                    next_state  = IDLE;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
